// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : instruction fetch with req/ready memory handshake and IF/ID
//               register; absorbs memory latency, decode stalls and flushes.
// Revision    : 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall_in,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        fetch_stall,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc4_q, ifpc4_d;
  logic        valid_q, valid_d;

  // DRAIN keeps presenting the abandoned address so the handshake completes cleanly.
  always_comb begin
    imem_req    = !reset && (state_q != HOLD);
    imem_addr   = (state_q == DRAIN) ? addr_q : pc;
    fetch_stall = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH:   fetch_stall = !imem_ready || (!flush && stall_in);
        default: fetch_stall = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = imem_req ? imem_addr : addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    instr_d      = instr_q;
    ifpc_d       = ifpc_q;
    ifpc4_d      = ifpc4_q;
    valid_d      = valid_q;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          if (flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end else if (stall_in) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc;
            state_d      = HOLD;
          end else begin
            instr_d = imem_rdata;
            ifpc_d  = pc;
            ifpc4_d = pc + PC_STEP;
            valid_d = 1'b1;
          end
        end else if (flush) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          state_d = DRAIN;
        end else if (!stall_in) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (flush) begin
          hold_instr_d = NOP_INSTR;
          hold_pc_d    = 32'd0;
          instr_d      = NOP_INSTR;
          valid_d      = 1'b0;
          state_d      = FETCH;
        end else if (!stall_in) begin
          instr_d = hold_instr_q;
          ifpc_d  = hold_pc_q;
          ifpc4_d = hold_pc_q + PC_STEP;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (imem_ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      addr_q       <= 32'd0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= 32'd0;
      instr_q      <= NOP_INSTR;
      ifpc_q       <= 32'd0;
      ifpc4_q      <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      instr_q      <= instr_d;
      ifpc_q       <= ifpc_d;
      ifpc4_q      <= ifpc4_d;
      valid_q      <= valid_d;
    end
  end

  assign if_id_instr    = instr_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_pc_plus4 = ifpc4_q;
  assign if_id_valid    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : directed self-checking bench for fetch_stage.
// Revision       : 1.0
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        stall_in;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        fetch_stall;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .stall_in       (stall_in),
    .flush          (flush),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .fetch_stall    (fetch_stall),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after the falling edge.
  task automatic drive(input logic [31:0] p, input logic rdy, input logic [31:0] rd,
                       input logic st, input logic fl);
    @(negedge clk);
    pc = p; imem_ready = rdy; imem_rdata = rd; stall_in = st; flush = fl;
    #1;
  endtask

  task automatic comb(input string tag, input logic req, input logic [31:0] addr,
                      input logic fs);
    check({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
    check({tag, ".addr"},  imem_addr,            addr);
    check({tag, ".stall"}, {31'd0, fetch_stall}, {31'd0, fs});
  endtask

  task automatic edge_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p,
                           input logic [31:0] p4, input logic v);
    @(posedge clk);
    #1;
    check({tag, ".instr"}, if_id_instr,          ins);
    check({tag, ".pc"},    if_id_pc,             p);
    check({tag, ".pc4"},   if_id_pc_plus4,       p4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
  endtask

  task automatic reset_ifid(input string tag);
    check({tag, ".instr"}, if_id_instr,          32'h0);
    check({tag, ".pc"},    if_id_pc,             32'h0);
    check({tag, ".pc4"},   if_id_pc_plus4,       32'h0);
    check({tag, ".valid"}, {31'd0, if_id_valid}, 32'h0);
    check({tag, ".req"},   {31'd0, imem_req},    32'h0);
    check({tag, ".stall"}, {31'd0, fetch_stall}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; pc = 32'h0; stall_in = 1'b0; flush = 1'b0;
    imem_rdata = 32'h0; imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_ifid("rst");

    // Zero-wait fetch straight out of reset
    @(negedge clk);
    reset = 1'b0;
    drive(32'h0, 1'b1, 32'h2008_0005, 1'b0, 1'b0);
    comb("zw", 1'b1, 32'h0, 1'b0);
    edge_ifid("zw", 32'h2008_0005, 32'h0, 32'h4, 1'b1);

    // Three wait cycles produce bubbles
    for (int i = 0; i < 3; i++) begin
      drive(32'h40, 1'b0, 32'hXXXX_XXXX, 1'b0, 1'b0);
      comb("wait", 1'b1, 32'h40, 1'b1);
      edge_ifid("wait", 32'h0, 32'h0, 32'h4, 1'b0);
    end
    drive(32'h40, 1'b1, 32'h1111_2222, 1'b0, 1'b0);
    comb("wdone", 1'b1, 32'h40, 1'b0);
    edge_ifid("wdone", 32'h1111_2222, 32'h40, 32'h44, 1'b1);

    // Response under decode stall goes to the hold buffer
    drive(32'h60, 1'b1, 32'hAABB_CCDD, 1'b1, 1'b0);
    comb("cap", 1'b1, 32'h60, 1'b1);
    edge_ifid("cap", 32'h1111_2222, 32'h40, 32'h44, 1'b1);
    drive(32'h60, 1'b0, 32'h0, 1'b1, 1'b0);
    comb("hold", 1'b0, 32'h60, 1'b1);
    edge_ifid("hold", 32'h1111_2222, 32'h40, 32'h44, 1'b1);
    drive(32'h60, 1'b0, 32'h0, 1'b0, 1'b0);
    comb("rel", 1'b0, 32'h60, 1'b1);
    edge_ifid("rel", 32'hAABB_CCDD, 32'h60, 32'h64, 1'b1);

    // Flush while waiting: drain the stale request at its original address
    drive(32'h80, 1'b0, 32'h0, 1'b0, 1'b1);
    comb("fl", 1'b1, 32'h80, 1'b1);
    edge_ifid("fl", 32'h0, 32'h60, 32'h64, 1'b0);
    drive(32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    comb("drw", 1'b1, 32'h80, 1'b1);
    edge_ifid("drw", 32'h0, 32'h60, 32'h64, 1'b0);
    drive(32'h200, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    comb("drr", 1'b1, 32'h80, 1'b1);
    edge_ifid("drr", 32'h0, 32'h60, 32'h64, 1'b0);
    drive(32'h200, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
    comb("new", 1'b1, 32'h200, 1'b0);
    edge_ifid("new", 32'h0000_0013, 32'h200, 32'h204, 1'b1);

    // Wrap of pc+4
    drive(32'hFFFF_FFFC, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    edge_ifid("wrap", 32'h1234_5678, 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Flush in HOLD discards the buffered word
    drive(32'h500, 1'b1, 32'h5555_AAAA, 1'b1, 1'b0);
    edge_ifid("hcap", 32'h1234_5678, 32'hFFFF_FFFC, 32'h0, 1'b1);
    drive(32'h500, 1'b0, 32'h0, 1'b1, 1'b1);
    comb("hfl", 1'b0, 32'h500, 1'b1);
    edge_ifid("hfl", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0);
    drive(32'h504, 1'b0, 32'h0, 1'b1, 1'b0);
    comb("hflf", 1'b1, 32'h504, 1'b1);
    edge_ifid("hflf", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0);

    // Asynchronous reset in the middle of HOLD
    drive(32'h300, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
    edge_ifid("rh0", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0);
    drive(32'h300, 1'b0, 32'h0, 1'b1, 1'b0);
    comb("rh1", 1'b0, 32'h300, 1'b1);
    reset = 1'b1;
    #1;
    reset_ifid("rhold");
    @(negedge clk);
    reset = 1'b0;
    drive(32'h304, 1'b0, 32'h0, 1'b0, 1'b0);
    comb("rhrel", 1'b1, 32'h304, 1'b1);

    // Asynchronous reset in the middle of DRAIN
    flush = 1'b1;
    edge_ifid("rd0", 32'h0, 32'h0, 32'h0, 1'b0);
    drive(32'h400, 1'b0, 32'h0, 1'b0, 1'b0);
    comb("rd1", 1'b1, 32'h304, 1'b1);
    reset = 1'b1;
    #1;
    reset_ifid("rdrain");
    @(negedge clk);
    reset = 1'b0;
    drive(32'h400, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
    comb("rdrel", 1'b1, 32'h400, 1'b0);
    edge_ifid("rdrel", 32'h0BAD_F00D, 32'h400, 32'h404, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage, directly downstream of the PC-selection logic.
- Takes the current PC, issues a request to instruction memory using a req/ready handshake, and loads the IF/ID pipeline register (instruction, PC, PC+4, valid) consumed by decode.
- Absorbs variable memory latency, decode stalls and branch flushes.
- Drives fetch_stall back to the PC logic so the PC holds while a fetch is unresolved.

Parameters:
- NOP_INSTR, 32'h00000000, instruction word inserted as a bubble.
- PC_STEP, 32'd4, increment used to form if_id_pc_plus4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc  in  32  current PC from the PC logic; held stable by that logic while fetch_stall=1.
- stall_in  in  1  decode/hazard stall; IF/ID must not change.
- flush  in  1  branch/jump taken; discard the instruction in flight.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory response strobe, one cycle per request.
- fetch_stall  out  1  PC logic must hold the PC.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc  out  32  IF/ID PC of the instruction.
- if_id_pc_plus4  out  32  IF/ID PC+PC_STEP.
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (asynchronous, any time including mid-request):
  - State goes to FETCH.
  - if_id_instr=NOP_INSTR; if_id_pc, if_id_pc_plus4 and addr_q are 0; if_id_valid=0.
  - Hold buffer is cleared.
  - imem_req and fetch_stall are forced to 0 while reset=1.
  - Any outstanding memory response is ignored.
- addr_q latches imem_addr on every cycle that imem_req=1.
- Handshake rules:
  - imem_req stays high, with imem_addr stable, until the cycle imem_ready=1.
  - Zero-wait memory is allowed: ready in the same cycle as req.
- States: FETCH, HOLD, DRAIN.
- FETCH: imem_req=1, imem_addr=pc.
  - ready & flush: IF/ID becomes a bubble (valid=0, instr=NOP_INSTR; pc fields unchanged). Stay in FETCH; fetch_stall=0.
  - ready & !flush & stall_in: capture {rdata, pc} in the hold buffer. IF/ID unchanged. fetch_stall=1. Go to HOLD.
  - ready & !flush & !stall_in: IF/ID <= {rdata, pc, pc+PC_STEP, valid=1}. fetch_stall=0. Stay in FETCH. Latency is 1 cycle from ready to IF/ID.
  - !ready & flush: IF/ID becomes a bubble. fetch_stall=1. Go to DRAIN.
  - !ready & !flush & stall_in: IF/ID unchanged; fetch_stall=1.
  - !ready & !flush & !stall_in: IF/ID becomes a bubble; fetch_stall=1.
- HOLD: imem_req=0, fetch_stall=1.
  - flush: discard the hold buffer; IF/ID becomes a bubble; go to FETCH.
  - !stall_in: IF/ID <= hold buffer (pc_plus4 = held pc+PC_STEP, valid=1); go to FETCH.
  - Otherwise stay in HOLD; IF/ID unchanged.
- DRAIN: imem_req=1, imem_addr=addr_q, fetch_stall=1.
  - On ready: discard rdata; go to FETCH.
  - IF/ID keeps its bubble unless stall_in=0, in which case it stays a bubble anyway.
  - A further flush in DRAIN has no extra effect.
- Priority: reset > flush > stall_in > normal update.
- Arithmetic: pc+PC_STEP wraps modulo 2^32 (32'hFFFFFFFC+4 = 0). Unsigned, no carry out.
- if_id_* change only on rising clk edges; outputs are registered. imem_req, imem_addr and fetch_stall are combinational from state, pc, addr_q and the inputs.

Test Plan:
- Reset, then pc=0x00, ready the same cycle with rdata=0x20080005 -> next edge: if_id_instr=0x20080005, if_id_pc=0, if_id_pc_plus4=4, valid=1; fetch_stall=0.
- pc=0x40, ready delayed 3 cycles -> imem_addr=0x40 and fetch_stall=1 for 3 cycles, IF/ID bubbles (valid=0); then if_id_pc=0x40, if_id_pc_plus4=0x44.
- Response 0xAABBCCDD arrives while stall_in=1 for 2 cycles -> HOLD, imem_req=0, IF/ID unchanged; one edge after stall_in falls, IF/ID=0xAABBCCDD, valid=1.
- Flush while waiting at pc=0x80, then pc changes to 0x200 -> imem_addr stays 0x80 until ready; rdata discarded, valid=0; the next request uses imem_addr=0x200.
- pc=32'hFFFFFFFC fetched -> if_id_pc_plus4=0.
- Reset asserted mid-HOLD and mid-DRAIN -> immediately valid=0, instr=NOP_INSTR, imem_req=0; after release, FETCH with imem_req=1 at the current pc.
